// File: rtl/ex_div.sv
// ex_div -- multi-cycle radix-2 restoring divider for the EX stage.
//
// Takes the operand pair and DIV/DIVU decode from the ID/EX register.
// It produces {remainder (HI), quotient (LO)} for the HI/LO write path.
// While a divide is in flight it holds the pipeline through stall_o.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   start_i     request a divide (sampled only in IDLE)
//   signed_i    1 = DIV (two's complement), 0 = DIVU
//   dividend_i  dividend, sampled with start_i
//   divisor_i   divisor, sampled with start_i
//   annul_i     flush input (present only with EX_DIV_ANNUL_EN)
//   result_o    {remainder, quotient}; updated on entry to END
//   ready_o     one-cycle pulse while in END
//   stall_o     pipeline hold: (IDLE & start) | ON | DIVZERO
//
// Optional feature: define EX_DIV_ANNUL_EN to add annul_i.
// When annul_i is high in ON or DIVZERO, the operation is abandoned silently.
// When it is high in IDLE, the operation is not accepted.

module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
`ifdef EX_DIV_ANNUL_EN
    input  logic               annul_i,
`endif
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   rem_reg;        // partial remainder
    logic [WIDTH-1:0]   quo_reg;        // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dvs_reg;        // divisor magnitude
    logic [CW-1:0]      cnt_reg;
    logic               neg_quo_reg;
    logic               neg_rem_reg;
    logic [2*WIDTH-1:0] result_reg;

    logic               annul;
`ifdef EX_DIV_ANNUL_EN
    assign annul = annul_i;
`else
    assign annul = 1'b0;
`endif

    // Operand magnitudes. The magnitude of the most negative value is still
    // correct when it is read as unsigned, so no overflow trap is needed.
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    assign dvd_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign dvs_mag = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // One restoring step. The shifted remainder is below 2*divisor, so a
    // WIDTH+1 bit subtraction is enough, and its MSB is the borrow.
    logic [WIDTH:0]   shifted, diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;
    logic             last_step;

    assign shifted   = {rem_reg, quo_reg[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_reg};
    assign borrow    = diff[WIDTH];
    assign rem_step  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_step  = {quo_reg[WIDTH-2:0], ~borrow};
    assign quo_fix   = neg_quo_reg ? -quo_step : quo_step;
    assign rem_fix   = neg_rem_reg ? -rem_step : rem_step;
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i && !annul)
                    state_next = (divisor_i == '0) ? DIVZERO : ON;
            end
            DIVZERO: state_next = annul ? IDLE : END;
            ON: begin
                if (annul)
                    state_next = IDLE;
                else if (last_step)
                    state_next = END;
            end
            END:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            cnt_reg     <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start_i && !annul && divisor_i != '0) begin
                        rem_reg     <= '0;
                        quo_reg     <= dvd_mag;
                        dvs_reg     <= dvs_mag;
                        cnt_reg     <= '0;
                        neg_quo_reg <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_rem_reg <= signed_i & dividend_i[WIDTH-1];
                    end
                end
                ON: begin
                    if (!annul) begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg + CW'(1);
                        // The result is written on the same edge that enters END.
                        if (last_step)
                            result_reg <= {rem_fix, quo_fix};
                    end
                end
                DIVZERO: begin
                    if (!annul)
                        result_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_reg;
    assign ready_o  = (state_reg == END);
    assign stall_o  = ((state_reg == IDLE) && start_i && !annul) ||
                      (state_reg == ON) || (state_reg == DIVZERO);

endmodule
